egr_dpb_req_arb: RTL and testbench
==================================

Name: egr_dpb_req_arb

Overview:
- Round-robin arbiter that shares the Dirty Pointer Broker (DPB) return path between N_REQ Packet Fetch Scheduler (PFS) requesters in the MBY egress pipeline.
- Each PFS requester offers one dirty pointer per cycle, tagged with valid/ready.
- Granted pointers are queued in a FIFO and drained to the DPB, tagged with the source requester index, under a valid/ready handshake.

Parameters:
- N_REQ, 4, number of PFS requesters; range 2..16.
- PTR_W, 20, dirty pointer width in bits.
- FIFO_DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- SRC_W, $clog2(N_REQ), width of the source index (derived).
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy count (derived).

Ports:
- cclk  input  1  core clock; all state is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_en  input  1  arbitration enable; 0 blocks all grants, drain continues.
- req_valid  input  N_REQ  per-requester pointer offer.
- req_ptr  input  N_REQ*PTR_W  packed pointers; requester i uses bits [i*PTR_W +: PTR_W].
- req_ready  output  N_REQ  one-hot grant (combinational); transfer happens when req_valid[i] & req_ready[i].
- out_valid  output  1  FIFO head is valid.
- out_ptr  output  PTR_W  head pointer.
- out_src  output  SRC_W  requester index of the head pointer.
- out_ready  input  1  DPB accepts the head.
- fifo_cnt  output  CNT_W  current occupancy, 0..FIFO_DEPTH.
- push_err  output  1  sticky; set if a push is attempted while full (assertion aid, never expected).

Behaviour:
- Reset values:
  - req_ready=0, out_valid=0, out_ptr=0, out_src=0, fifo_cnt=0, push_err=0.
  - Round-robin priority pointer rr=0; FIFO read and write pointers=0.
  - FIFO memory contents are don't-care.
- Grant eligibility: grant_ok = cfg_en & (fifo_cnt < FIFO_DEPTH).
  - A same-cycle pop does NOT free a slot for a grant at full; there is no bypass.
- Arbitration (combinational):
  - Scan requesters starting at rr, upward with wrap modulo N_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1 when grant_ok.
  - At most one bit of req_ready is set; req_ready=0 when grant_ok=0 or no requester is valid.
  - req_ready does not depend on out_ready.
- rr update:
  - On a grant to requester g, rr <= (g+1) mod N_REQ on the next edge.
  - With no grant, rr holds.
  - Wrap: a grant to N_REQ-1 sets rr=0.
- Push:
  - On a grant, {g, req_ptr[g]} is written at wr_ptr.
  - wr_ptr advances modulo FIFO_DEPTH (natural wrap of the index bits).
- Pop:
  - out_valid = (fifo_cnt != 0).
  - out_ptr/out_src are read combinationally from mem[rd_ptr]; they are 0 when empty.
  - When out_valid & out_ready, rd_ptr advances modulo FIFO_DEPTH.
  - out_ready while empty is ignored.
- Count:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
  - fifo_cnt never exceeds FIFO_DEPTH and never goes below 0.
- Latency:
  - A pointer granted at edge N is visible on out_valid/out_ptr after edge N (the cycle after acceptance) if the FIFO was empty.
  - There is no combinational path from req_* to out_*.
- Ordering: the FIFO preserves grant order; there is no reordering per source.
- Handshake rules:
  - Requesters may drop req_valid without a grant.
  - out_* is held stable while out_valid=1 and out_ready=0.
- cfg_en:
  - Deasserting it stops new grants in the same cycle (combinational).
  - rr holds while cfg_en=0.
  - Queued entries still drain.
- Reset mid-operation:
  - All queued pointers are discarded.
  - Outputs go to their reset values asynchronously on rst assertion.
  - Operation resumes on the first edge after deassertion.
- push_err: set when a write enable occurs with fifo_cnt==FIFO_DEPTH; cleared only by rst.

Test Plan:
- Single requester: req_valid=0001, ptr 0x00ABC, out_ready=1 -> req_ready=0001 the same cycle; out_valid=1, out_ptr=0x00ABC, out_src=0 the next cycle; fifo_cnt returns to 0.
- All 4 requesters held valid with out_ready=1 from reset -> grant order 0,1,2,3,0,1...; out_src sequence identical, one entry per cycle.
- Fill to full:
  - out_ready=0 with all requesters valid -> 8 grants, then req_ready=0, fifo_cnt=8.
  - Assert out_ready for 1 cycle -> pop while no grant that cycle; the next cycle has exactly one grant.
- Wrap-around: stream 20 pointers 0x1..0x14 from requester 2 with out_ready toggling 1/0 -> outputs are 0x1..0x14 in order, out_src=2, push_err stays 0.
- cfg_en=0 with 3 entries queued and all requesters valid -> req_ready=0, the 3 entries drain, rr unchanged; cfg_en=1 resumes at the previous rr.
- Assert rst while fifo_cnt=5 -> out_valid=0, fifo_cnt=0, rr=0 immediately; after release, requester 0 wins the first grant.

Source files
------------

// File: rtl/egr_dpb_req_arb.sv
// egr_dpb_req_arb: round-robin arbiter that merges N_REQ PFS dirty-pointer
// streams into one FIFO and drains it toward the DPB with the source index.
module egr_dpb_req_arb #(
   parameter int N_REQ      = 4,
   parameter int PTR_W      = 20,
   parameter int FIFO_DEPTH = 8,
   parameter int SRC_W      = $clog2(N_REQ),
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                   cclk,
   input  logic                   rst,
   input  logic                   cfg_en,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*PTR_W-1:0] req_ptr,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   out_valid,
   output logic [PTR_W-1:0]       out_ptr,
   output logic [SRC_W-1:0]       out_src,
   input  logic                   out_ready,
   output logic [CNT_W-1:0]       fifo_cnt,
   output logic                   push_err
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [SRC_W-1:0] rr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [PTR_W-1:0] mem_ptr [FIFO_DEPTH];
   logic [SRC_W-1:0] mem_src [FIFO_DEPTH];

   logic             full;
   logic             grant_ok;
   logic             grant;
   logic             pop;
   logic [SRC_W-1:0] grant_idx;

   // No bypass at full: a same-cycle pop does not open a slot for a grant.
   // Grants are also held off while rst is asserted so req_ready reads 0.
   assign full      = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign grant_ok  = cfg_en & ~full & ~rst;
   assign out_valid = (fifo_cnt != '0);
   assign pop       = out_valid & out_ready;

   // Round-robin scan from rr upward with wrap; first valid requester wins.
   always_comb begin
      int idx;
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      idx       = 0;
      req_ready = '0;
      grant     = 1'b0;
      grant_idx = '0;
      if (grant_ok) begin
         for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant && req_valid[idx]) begin
               grant          = 1'b1;
               grant_idx      = SRC_W'(idx);
               req_ready[idx] = 1'b1;
            end
         end
      end
   end

   // Head of the FIFO is read combinationally; forced to 0 when empty.
   always_comb begin
      out_ptr = '0;
      out_src = '0;
      if (out_valid) begin
         out_ptr = mem_ptr[rd_ptr];
         out_src = mem_src[rd_ptr];
      end
   end

   // FIFO storage write; contents are don't-care after reset.
   // NOTE: the memory array has no reset; out_valid gating makes stale contents invisible.
   always_ff @(posedge cclk) begin
      if (grant) begin
         mem_ptr[wr_ptr] <= req_ptr[int'(grant_idx)*PTR_W +: PTR_W];
         mem_src[wr_ptr] <= grant_idx;
      end
   end

   // Control state: priority pointer, FIFO pointers, occupancy and sticky error.
   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         rr       <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         push_err <= 1'b0;
      end else begin
         if (grant) begin
            rr     <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + SRC_W'(1);
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({grant, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
         if (grant && full) push_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_egr_dpb_req_arb.sv
// Directed bench for egr_dpb_req_arb: inputs change on the falling edge,
// combinational outputs are sampled just after it, registered ones just after the rising edge.
module tb_egr_dpb_req_arb;

   localparam int N_REQ      = 4;
   localparam int PTR_W      = 20;
   localparam int FIFO_DEPTH = 8;
   localparam int SRC_W      = 2;
   localparam int CNT_W      = 4;

   logic                   cclk = 1'b0;
   logic                   rst;
   logic                   cfg_en;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*PTR_W-1:0] req_ptr;
   logic [N_REQ-1:0]       req_ready;
   logic                   out_valid;
   logic [PTR_W-1:0]       out_ptr;
   logic [SRC_W-1:0]       out_src;
   logic                   out_ready;
   logic [CNT_W-1:0]       fifo_cnt;
   logic                   push_err;

   int n_checks = 0;
   int n_errors = 0;

   egr_dpb_req_arb #(
      .N_REQ(N_REQ), .PTR_W(PTR_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .cclk(cclk), .rst(rst), .cfg_en(cfg_en),
      .req_valid(req_valid), .req_ptr(req_ptr), .req_ready(req_ready),
      .out_valid(out_valid), .out_ptr(out_ptr), .out_src(out_src),
      .out_ready(out_ready), .fifo_cnt(fifo_cnt), .push_err(push_err)
   );

   always #5 cclk = ~cclk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Distinct pointer per requester: 0x100 + i.
   task automatic load_ptrs();
      for (int i = 0; i < N_REQ; i++) req_ptr[i*PTR_W +: PTR_W] = PTR_W'(32'h100 + i);
   endtask

   task automatic do_reset();
      @(negedge cclk);
      rst       = 1'b1;
      req_valid = '0;
      out_ready = 1'b0;
      cfg_en    = 1'b1;
      @(negedge cclk);
      rst = 1'b0;
   endtask

   initial begin
      int sent, rcvd;
      rst = 1'b1; cfg_en = 1'b1; req_valid = '0; req_ptr = '0; out_ready = 1'b0;

      // Reset state.
      #12;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_ptr",   32'(out_ptr),   32'h0);
      check("rst_out_src",   32'(out_src),   32'h0);
      check("rst_fifo_cnt",  32'(fifo_cnt),  32'h0);
      check("rst_push_err",  32'(push_err),  32'h0);

      // Single requester, one-cycle latency to the output.
      @(negedge cclk); rst = 1'b0;
      @(negedge cclk);
      req_valid = 4'b0001; req_ptr[0 +: PTR_W] = 20'h00ABC; out_ready = 1'b1;
      #1 check("single_ready", 32'(req_ready), 32'h1);
      @(posedge cclk); #1;
      req_valid = '0;
      check("single_valid", 32'(out_valid), 32'h1);
      check("single_ptr",   32'(out_ptr),   32'h00ABC);
      check("single_src",   32'(out_src),   32'h0);
      check("single_cnt",   32'(fifo_cnt),  32'h1);
      @(posedge cclk); #1;
      check("single_drain", 32'(fifo_cnt),  32'h0);

      // All requesters valid, drain every cycle: order 0,1,2,3,0,...
      do_reset();
      load_ptrs(); req_valid = 4'hF; out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1 check("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
         @(posedge cclk); #1;
         check("rr_src", 32'(out_src),  32'(c % 4));
         check("rr_ptr", 32'(out_ptr),  32'h100 + 32'(c % 4));
         check("rr_cnt", 32'(fifo_cnt), 32'h1);
         @(negedge cclk);
      end

      // Fill to full with no drain, then one pop with no bypass grant.
      do_reset();
      load_ptrs(); req_valid = 4'hF; out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1 check("fill_grant", 32'(req_ready), 32'(1 << (c % 4)));
         @(negedge cclk);
      end
      #1;
      check("full_cnt",   32'(fifo_cnt),  32'd8);
      check("full_ready", 32'(req_ready), 32'h0);
      out_ready = 1'b1;
      #1 check("full_pop_nobypass", 32'(req_ready), 32'h0);
      @(negedge cclk);
      out_ready = 1'b0;
      #1;
      check("after_pop_cnt",   32'(fifo_cnt),  32'd7);
      check("after_pop_src",   32'(out_src),   32'h1);
      check("after_pop_grant", 32'(req_ready), 32'h1);
      @(negedge cclk); #1;
      check("refill_cnt",      32'(fifo_cnt),  32'd8);
      check("refill_ready",    32'(req_ready), 32'h0);
      check("full_push_err",   32'(push_err),  32'h0);

      // Wrap-around: 20 pointers from requester 2, consumer ready every other cycle.
      do_reset();
      req_ptr = '0; sent = 0; rcvd = 0;
      for (int c = 0; c < 200 && rcvd < 20; c++) begin
         out_ready = c[0];
         req_valid = (sent < 20) ? 4'b0100 : 4'b0000;
         req_ptr[2*PTR_W +: PTR_W] = PTR_W'(sent + 1);
         #1;
         if (out_valid && out_ready) begin
            check("wrap_ptr", 32'(out_ptr), 32'(rcvd + 1));
            check("wrap_src", 32'(out_src), 32'h2);
            rcvd++;
         end
         if (req_valid[2] && req_ready[2]) sent++;
         @(negedge cclk);
      end
      req_valid = '0; out_ready = 1'b0;
      check("wrap_rcvd",     32'(rcvd),     32'd20);
      check("wrap_push_err", 32'(push_err), 32'h0);

      // cfg_en=0 blocks grants while queued entries drain; rr holds.
      do_reset();
      load_ptrs(); req_valid = 4'hF; out_ready = 1'b0;
      repeat (3) @(negedge cclk);
      cfg_en = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("dis_ready", 32'(req_ready), 32'h0);
         check("dis_src",   32'(out_src),   32'(c));
         check("dis_cnt",   32'(fifo_cnt),  32'(3 - c));
         @(negedge cclk);
      end
      #1;
      check("dis_empty_valid", 32'(out_valid), 32'h0);
      @(negedge cclk); #1;
      check("empty_pop_ignored", 32'(fifo_cnt), 32'h0);
      cfg_en = 1'b1;
      #1 check("resume_rr", 32'(req_ready), 32'h8);

      // Reset mid-operation with 5 entries queued.
      do_reset();
      load_ptrs(); req_valid = 4'hF; out_ready = 1'b0;
      repeat (5) @(negedge cclk);
      #1 check("pre_rst_cnt", 32'(fifo_cnt), 32'd5);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'h0);
      check("mid_rst_cnt",   32'(fifo_cnt),  32'h0);
      check("mid_rst_ptr",   32'(out_ptr),   32'h0);
      check("mid_rst_ready", 32'(req_ready), 32'h0);
      @(negedge cclk);
      rst = 1'b0;
      #1 check("post_rst_grant", 32'(req_ready), 32'h1);
      @(negedge cclk); #1;
      check("post_rst_src", 32'(out_src),  32'h0);
      check("post_rst_cnt", 32'(fifo_cnt), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
